// File: rtl/scoreboard_digit_scan.sv
// Four-digit multiplexed score display scanner: prescaled one-hot digit rotation,
// double-buffered score (pending + shadow) swapped only at frame boundaries.
module scoreboard_digit_scan #(
  parameter int DIV        = 50000,
  parameter int LEAD_BLANK = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        score_valid,
  input  logic [15:0] score_in,
  output logic        score_ready,
  output logic [3:0]  code,
  output logic [3:0]  digit,
  output logic        blank,
  output logic        frame_done
);

  localparam logic [19:0] LAST = 20'(DIV - 1);

  logic [19:0] count;
  logic        tick;
  logic        boundary;
  logic        accept;
  logic [15:0] pending;
  logic [15:0] shadow;
  logic        pending_full;
  logic [3:0]  zero_above;

  assign tick     = (count == LAST);
  assign boundary = tick && code[3];

  // Handshake: a score transfers on any rising edge where score_valid and
  // score_ready are both high; score_ready depends only on internal state.
  assign score_ready = ~pending_full;
  assign accept      = score_valid && score_ready;
  assign frame_done  = boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + 20'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code <= 4'b0001;
    end else if (tick) begin
      code <= {code[2:0], code[3]};
    end
  end

  // accept and the boundary transfer are exclusive: accept needs pending empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending      <= '0;
      pending_full <= 1'b0;
      shadow       <= '0;
    end else if (accept) begin
      pending      <= score_in;
      pending_full <= 1'b1;
    end else if (boundary && pending_full) begin
      shadow       <= pending;
      pending_full <= 1'b0;
    end
  end

  always_comb begin
    digit = ({4{code[0]}} & shadow[3:0])
          | ({4{code[1]}} & shadow[7:4])
          | ({4{code[2]}} & shadow[11:8])
          | ({4{code[3]}} & shadow[15:12]);
  end

  // zero_above[k]: nibbles k..3 are all zero; digit 0 is never dark.
  always_comb begin
    zero_above    = 4'b0000;
    zero_above[1] = (shadow[15:4] == 12'd0);
    zero_above[2] = (shadow[15:8] == 8'd0);
    zero_above[3] = (shadow[15:12] == 4'd0);
    blank         = (LEAD_BLANK != 0) && ((code & zero_above) != 4'b0000);
  end

endmodule

// File: tb/tb_scoreboard_digit_scan.sv
// Bench for scoreboard_digit_scan (DIV=4): randomized and directed stimulus checked
// against a slot-arithmetic reference model with a pending-score queue.
module tb_scoreboard_digit_scan;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        score_valid = 1'b0;
  logic [15:0] score_in = 16'h0000;
  logic        score_ready, blank, frame_done;
  logic [3:0]  code, digit;
  logic        score_ready0, blank0, frame_done0;
  logic [3:0]  code0, digit0;

  int checks = 0;
  int errors = 0;

  scoreboard_digit_scan #(.DIV(DIV), .LEAD_BLANK(1)) dut (
    .clk(clk), .rst_n(rst_n), .score_valid(score_valid), .score_in(score_in),
    .score_ready(score_ready), .code(code), .digit(digit), .blank(blank),
    .frame_done(frame_done));

  scoreboard_digit_scan #(.DIV(DIV), .LEAD_BLANK(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .score_valid(score_valid), .score_in(score_in),
    .score_ready(score_ready0), .code(code0), .digit(digit0), .blank(blank0),
    .frame_done(frame_done0));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // m_n = rising edges since reset release; the slot is m_n/DIV mod 4.
  int          m_n = 0;
  logic [15:0] m_shadow = 16'h0000;
  logic [15:0] exp_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_n = 0;
      m_shadow = 16'h0000;
      exp_q.delete();
    end else begin
      if (score_valid && exp_q.size() == 0)
        exp_q.push_back(score_in);
      else if ((m_n % DIV == DIV - 1) && ((m_n / DIV) % 4 == 3) && exp_q.size() != 0)
        m_shadow = exp_q.pop_front();
      m_n++;
    end
  end

  // {code, digit, blank, ready, frame_done}
  function automatic logic [10:0] exp_vec(input bit lead_blank);
    int          slot;
    logic [15:0] upper;
    logic [3:0]  e_code;
    logic        e_blank, e_fd, e_ready;
    slot    = (m_n / DIV) % 4;
    upper   = m_shadow >> (4 * slot);
    e_code  = 4'b0001 << slot;
    e_blank = lead_blank && (slot != 0) && (upper == 16'h0000);
    e_fd    = (m_n % DIV == DIV - 1) && (slot == 3);
    e_ready = (exp_q.size() == 0);
    return {e_code, upper[3:0], e_blank, e_ready, e_fd};
  endfunction

  function automatic logic [15:0] rand_score();
    logic [15:0] s;
    for (int k = 0; k < 4; k++)
      s[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    return s;
  endfunction

  // ---------------- driver / scenario tasks ----------------
  task automatic test_reset();
    logic [10:0] got;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    got = {code, digit, blank, score_ready, frame_done};
    checks++;
    if (got !== 11'b0001_0000_0_1_0) begin
      errors++;
      $display("FAIL reset_values: got %b want %b", got, 11'b0001_0000_0_1_0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    logic [10:0] got;
    int pulses = 0;
    int pulse_at = -1;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      got = {code, digit, blank, score_ready, frame_done};
      checks++;
      if (got !== exp_vec(1'b1)) begin
        errors++;
        $display("FAIL free_run cycle %0d: got %b want %b", i, got, exp_vec(1'b1));
      end
      if (frame_done) begin
        pulses++;
        pulse_at = i;
      end
    end
    checks++;
    if (pulses !== 1 || pulse_at !== 15) begin
      errors++;
      $display("FAIL free_run_frame_done: got %0d pulses at %0d want 1 at 15", pulses, pulse_at);
    end
    checks++;
    if (code !== 4'b0001) begin
      errors++;
      $display("FAIL free_run_wrap: code %b want 0001", code);
    end
  endtask

  task automatic test_score_0123();
    logic [10:0] got;
    repeat (5) begin
      @(posedge clk); #1;
    end
    score_valid = 1'b1;
    score_in    = 16'h0123;
    @(posedge clk); #1;
    score_valid = 1'b0;
    checks++;
    if (score_ready !== 1'b0) begin
      errors++;
      $display("FAIL score_0123_ready_drop: got %b want 0", score_ready);
    end
    for (int i = 0; i < 27; i++) begin
      @(posedge clk); #1;
      got = {code, digit, blank, score_ready, frame_done};
      checks++;
      if (got !== exp_vec(1'b1)) begin
        errors++;
        $display("FAIL score_0123 cycle %0d: got %b want %b", i, got, exp_vec(1'b1));
      end
    end
    checks++;
    if (score_ready !== 1'b1) begin
      errors++;
      $display("FAIL score_0123_ready_return: got %b want 1", score_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [10:0] got;
    bit was_ready;
    bit sent = 0;
    int seen7 = 0;
    score_valid = 1'b1;
    score_in    = 16'h0042;
    @(posedge clk); #1;
    score_in = 16'h0777;
    for (int i = 0; i < 100 && !sent; i++) begin
      was_ready = score_ready;
      got = {code, digit, blank, score_ready, frame_done};
      checks++;
      if (got !== exp_vec(1'b1)) begin
        errors++;
        $display("FAIL back_to_back hold %0d: got %b want %b", i, got, exp_vec(1'b1));
      end
      @(posedge clk); #1;
      if (was_ready) sent = 1;
    end
    score_valid = 1'b0;
    checks++;
    if (!sent) begin
      errors++;
      $display("FAIL back_to_back_timeout: second score never accepted (got 0 want 1)");
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      got = {code, digit, blank, score_ready, frame_done};
      checks++;
      if (got !== exp_vec(1'b1)) begin
        errors++;
        $display("FAIL back_to_back cycle %0d: got %b want %b", i, got, exp_vec(1'b1));
      end
      if (code == 4'b0100 && digit == 4'h7) seen7++;
    end
    checks++;
    if (seen7 == 0) begin
      errors++;
      $display("FAIL back_to_back_0777_shown: got %0d slot-2 sevens want >0", seen7);
    end
  endtask

  task automatic test_blank();
    logic [10:0] got, got0;
    int seen_a = 0;
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      got  = {code, digit, blank, score_ready, frame_done};
      got0 = {code0, digit0, blank0, score_ready0, frame_done0};
      checks++;
      if (got !== exp_vec(1'b1) || got0 !== exp_vec(1'b0)) begin
        errors++;
        $display("FAIL blank_zero cycle %0d: got %b/%b want %b/%b", i, got, got0,
                 exp_vec(1'b1), exp_vec(1'b0));
      end
      checks++;
      if (blank !== (code != 4'b0001)) begin
        errors++;
        $display("FAIL blank_zero_lead cycle %0d: blank %b want %b", i, blank, code != 4'b0001);
      end
    end
    score_valid = 1'b1;
    score_in    = 16'h00A5;
    @(posedge clk); #1;
    score_valid = 1'b0;
    for (int i = 0; i < 36; i++) begin
      @(posedge clk); #1;
      got  = {code, digit, blank, score_ready, frame_done};
      got0 = {code0, digit0, blank0, score_ready0, frame_done0};
      checks++;
      if (got !== exp_vec(1'b1) || got0 !== exp_vec(1'b0)) begin
        errors++;
        $display("FAIL blank_00a5 cycle %0d: got %b/%b want %b/%b", i, got, got0,
                 exp_vec(1'b1), exp_vec(1'b0));
      end
      if (code == 4'b0010 && digit == 4'hA && blank == 1'b0) seen_a++;
    end
    checks++;
    if (seen_a == 0) begin
      errors++;
      $display("FAIL blank_00a5_digit1: got %0d unblanked A cycles want >0", seen_a);
    end
  endtask

  task automatic test_random();
    logic [10:0] got, got0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      got  = {code, digit, blank, score_ready, frame_done};
      got0 = {code0, digit0, blank0, score_ready0, frame_done0};
      checks++;
      if (got !== exp_vec(1'b1) || got0 !== exp_vec(1'b0)) begin
        errors++;
        $display("FAIL random cycle %0d: got %b/%b want %b/%b", i, got, got0,
                 exp_vec(1'b1), exp_vec(1'b0));
      end
      score_valid = ($urandom_range(0, 3) == 0);
      score_in    = rand_score();
    end
    score_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [10:0] got;
    bit hit = 0;
    int nonzero = 0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(posedge clk); #1;
      score_valid = 1'b1;
      score_in    = 16'h9876;
      hit = (code == 4'b0100) && (score_ready == 1'b0);
    end
    score_valid = 1'b0;
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL async_reset_setup: got 0 want 1 (code 0100 with pending)");
    end
    #2 rst_n = 1'b0;
    #1;
    got = {code, digit, blank, score_ready, frame_done};
    checks++;
    if (got !== 11'b0001_0000_0_1_0) begin
      errors++;
      $display("FAIL async_reset_values: got %b want %b", got, 11'b0001_0000_0_1_0);
    end
    #3 rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      got = {code, digit, blank, score_ready, frame_done};
      checks++;
      if (got !== exp_vec(1'b1)) begin
        errors++;
        $display("FAIL async_reset cycle %0d: got %b want %b", i, got, exp_vec(1'b1));
      end
      if (digit != 4'h0) nonzero++;
    end
    checks++;
    if (nonzero != 0) begin
      errors++;
      $display("FAIL async_reset_discard: got %0d nonzero digits want 0", nonzero);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_free_run();
    test_score_0123();
    test_back_to_back();
    test_blank();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
